ndf_page_reader: RTL and testbench
==================================

Name: ndf_page_reader

Overview:
- Autonomous NAND page-read sequencer that sits directly downstream of the EPP command front end. The front end loads a row/column address and pulses start; this block then drives the NAND pins itself.
- NAND command sequence issued: 00h, 2 column bytes, 3 row bytes, 30h, then wait on R/B, then RE-clocked reads.
- Read bytes leave on a valid/ready byte stream toward the EPP readout path, so a host reads a full page without issuing one 'D' per byte.

Parameters:
- PAGE_BYTES, 4096, bytes read per start (1..65535).
- RB_TIMEOUT, 2000, clk10 cycles to wait for R/B high before flagging an error (200 us at 10 MHz).
- TWB_CYCLES, 2, clk10 cycles after the 30h WE rise before R/B is first sampled.

Ports:
- clk10  in  1  system clock, 10 MHz
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- col_addr  in  16  column address, low byte sent first
- row_addr  in  24  row address, low byte sent first
- busy  out  1  high from the cycle after an accepted start until DONE/ERR
- done  out  1  one-cycle pulse after the last byte is accepted
- timeout_err  out  1  sticky; cleared by next accepted start or rst
- ndf_ce_n  out  1  chip enable, low while busy
- ndf_cle  out  1  command latch enable
- ndf_ale  out  1  address latch enable
- ndf_we_n  out  1  write enable
- ndf_re_n  out  1  read enable
- ndf_io_out  out  8  bus drive value
- ndf_io_oe  out  1  bus output enable; top level tristates when 0
- ndf_io_in  in  8  bus sample value
- ndf_r_b_n  in  1  ready/busy_n, asynchronous open drain
- out_data  out  8  read byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when valid and ready on the same edge

Behaviour:
- All outputs registered.
- Reset values: ndf_ce_n=1, cle=0, ale=0, we_n=1, re_n=1, io_oe=0, io_out=00h, out_valid=0, out_data=00h, busy=0, done=0, timeout_err=0. State returns to IDLE.
- Reset mid-operation aborts immediately; the same reset values apply on the next edge, and no partial byte is emitted.
- r_b_n is synchronised with 2 flops before use.
- Write cycle (command or address byte), 2 cycles:
  - W0: we_n=0, io_oe=1, io_out=byte, cle or ale=1.
  - W1: we_n=1, same byte, same latch.
  - The next byte follows immediately.
- States:
  - IDLE: waits for start; latches addresses; clears timeout_err; sets ce_n=0.
  - CMD1: writes 00h with cle.
  - ADDR: writes 5 bytes with ale (col[7:0], col[15:8], row[7:0], row[15:8], row[23:16]). A 3-bit index wraps 0..4.
  - CMD2: writes 30h with cle.
  - TWB: io_oe=0; waits TWB_CYCLES.
  - WAITRDY: counts cycles while synced R/B=0; goes to READ when R/B=1. When the count reaches RB_TIMEOUT, goes to ERR.
  - READ, 3 cycles per byte:
    - R0: re_n=0.
    - R1: re_n=0; ndf_io_in captured into out_data at the end of R1.
    - R2: re_n=1; out_valid=1.
  - HOLD: out_valid stays 1 and re_n stays 1 until out_ready. On accept, the byte counter increments and the next byte starts at R0, or the block goes to DONE after byte PAGE_BYTES-1.
  - Back-pressure: if out_ready is already 1 in R2, the byte is accepted in R2 and HOLD is skipped (3 cycles per byte at full rate).
  - DONE: done=1 for one cycle; ce_n=1; busy=0; then IDLE.
  - ERR: timeout_err=1; ce_n=1; busy=0; then IDLE without emitting bytes.
- The byte counter is 16 bits and is compared to PAGE_BYTES-1; no wrap past the page.
- start asserted while busy is ignored.
- start in the same cycle as rst: rst wins.
- io_oe is never 1 while re_n=0.

Optional Feature:
- Macro: NDF_RDSUM_EN.
- Defined: adds output port rd_sum[7:0], the running XOR of every accepted byte.
  - Cleared on accepted start and on rst.
  - Updated on each accept.
  - Final value is stable from the done pulse until the next start.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Start with col=0000h, row=012345h, out_ready=1, R/B high after 40 cycles -> bus writes in order 00h(cle), 00h, 00h, 45h, 23h, 01h (ale), 30h(cle), each exactly 2 cycles with we_n low for 1 cycle. ce_n=0 throughout, and PAGE_BYTES bytes are emitted.
- Model drives byte value = index[7:0], PAGE_BYTES=16, out_ready=1 -> out_data 00h..0Fh, one byte every 3 cycles, done 1 cycle after the 16th accept.
- Same setup with out_ready toggling 1-0-0-1 -> no byte lost or duplicated, re_n stays 1 while HOLD waits, out_data stable while valid and not ready.
- R/B held low, RB_TIMEOUT=50 -> timeout_err=1 after 50 WAITRDY cycles, zero out_valid pulses, ce_n returns to 1, busy=0. A new start clears timeout_err.
- rst asserted during the 7th read byte -> next edge: all outputs at reset values, no done. A subsequent start runs a full clean page.
- NDF_RDSUM_EN defined, 4 bytes A5h, 0Fh, F0h, 3Ch -> rd_sum=66h at done.

Source files
------------

// File: rtl/ndf_page_reader.sv
`timescale 1ns/1ps
// ndf_page_reader: autonomous NAND page-read sequencer.
// Issues 00h, 2 column bytes, 3 row bytes and 30h. It then waits on R/B and
// streams PAGE_BYTES RE-clocked bytes out on a valid/ready interface.
// Optional build macro NDF_RDSUM_EN adds rd_sum, the running XOR of the
// accepted bytes.
module ndf_page_reader #(
  parameter int unsigned PAGE_BYTES = 4096,
  parameter int unsigned RB_TIMEOUT = 2000,
  parameter int unsigned TWB_CYCLES = 2
) (
  input  logic        clk10,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] col_addr,
  input  logic [23:0] row_addr,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        ndf_ce_n,
  output logic        ndf_cle,
  output logic        ndf_ale,
  output logic        ndf_we_n,
  output logic        ndf_re_n,
  output logic [7:0]  ndf_io_out,
  output logic        ndf_io_oe,
  input  logic [7:0]  ndf_io_in,
  input  logic        ndf_r_b_n,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef NDF_RDSUM_EN
  , output logic [7:0] rd_sum
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_TWB, S_WAITRDY, S_READ, S_HOLD, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] LAST_BYTE = 16'(PAGE_BYTES - 1);
  localparam logic [31:0] TWB_LAST  = (TWB_CYCLES == 0) ? 32'd0 : 32'(TWB_CYCLES - 1);
  localparam logic [31:0] RB_LAST   = (RB_TIMEOUT == 0) ? 32'd0 : 32'(RB_TIMEOUT - 1);

  state_t      r_state, w_state;
  logic [1:0]  r_ph, w_ph;
  logic [2:0]  r_idx, w_idx;
  logic [31:0] r_cnt, w_cnt;
  logic [15:0] r_bcnt, w_bcnt;
  logic [15:0] r_col;
  logic [23:0] r_row;
  logic        r_rb_s1, r_rb_s2;
  logic [7:0]  r_data;
  logic        r_terr;

  logic        r_ce_n, r_cle, r_ale, r_we_n, r_re_n, r_io_oe, r_out_valid, r_busy, r_done;
  logic [7:0]  r_io_out;
  logic        w_ce_n, w_cle, w_ale, w_we_n, w_re_n, w_io_oe, w_out_valid, w_busy, w_done;
  logic [7:0]  w_io_out, w_abyte;
  logic        w_start_acc, w_accept;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_accept    = r_out_valid && out_ready;

  // Two-flop synchroniser for the asynchronous open-drain R/B line
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_rb_s1 <= 1'b1;
      r_rb_s2 <= 1'b1;
    end else begin
      r_rb_s1 <= ndf_r_b_n;
      r_rb_s2 <= r_rb_s1;
    end
  end

  // State register with its phase, address index and counters
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_ph    <= w_ph;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_bcnt  <= w_bcnt;
    end
  end

  // Next-state logic: write cycles use ph 0/1, read cycles use ph 0/1/2
  always_comb begin
    w_state = r_state;
    w_ph    = r_ph;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_bcnt  = r_bcnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_CMD1;
          w_ph    = '0;
          w_idx   = '0;
        end
      end
      S_CMD1: begin
        if (!r_ph[0]) begin
          w_ph = 2'd1;
        end else begin
          w_state = S_ADDR;
          w_ph    = '0;
          w_idx   = '0;
        end
      end
      S_ADDR: begin
        if (!r_ph[0]) begin
          w_ph = 2'd1;
        end else begin
          w_ph = '0;
          if (r_idx == 3'd4) begin
            w_state = S_CMD2;
            w_idx   = '0;
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end
      end
      S_CMD2: begin
        if (!r_ph[0]) begin
          w_ph = 2'd1;
        end else begin
          w_state = S_TWB;
          w_ph    = '0;
          w_cnt   = '0;
        end
      end
      S_TWB: begin
        if (r_cnt >= TWB_LAST) begin
          w_state = S_WAITRDY;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end
      S_WAITRDY: begin
        if (r_rb_s2) begin
          w_state = S_READ;
          w_ph    = '0;
          w_bcnt  = '0;
        end else if (r_cnt >= RB_LAST) begin
          w_state = S_ERR;
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end
      // R2 and HOLD share the accept path, so a ready consumer skips HOLD
      S_READ, S_HOLD: begin
        if (r_state == S_READ && r_ph != 2'd2) begin
          w_ph = r_ph + 2'd1;
        end else if (w_accept) begin
          if (r_bcnt == LAST_BYTE) begin
            w_state = S_DONE;
          end else begin
            w_state = S_READ;
            w_ph    = '0;
            w_bcnt  = r_bcnt + 16'd1;
          end
        end else begin
          w_state = S_HOLD;
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_ERR:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // Output decode from the next state; the values are registered below
  always_comb begin
    case (w_idx)
      3'd0:    w_abyte = r_col[7:0];
      3'd1:    w_abyte = r_col[15:8];
      3'd2:    w_abyte = r_row[7:0];
      3'd3:    w_abyte = r_row[15:8];
      default: w_abyte = r_row[23:16];
    endcase
    w_ce_n      = 1'b0;
    w_cle       = 1'b0;
    w_ale       = 1'b0;
    w_we_n      = 1'b1;
    w_re_n      = 1'b1;
    w_io_oe     = 1'b0;
    w_io_out    = '0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (w_state)
      S_IDLE: begin
        w_ce_n = 1'b1;
        w_busy = 1'b0;
      end
      S_CMD1: begin
        w_cle   = 1'b1;
        w_io_oe = 1'b1;
        w_we_n  = w_ph[0];
      end
      S_ADDR: begin
        w_ale    = 1'b1;
        w_io_oe  = 1'b1;
        w_we_n   = w_ph[0];
        w_io_out = w_abyte;
      end
      S_CMD2: begin
        w_cle    = 1'b1;
        w_io_oe  = 1'b1;
        w_we_n   = w_ph[0];
        w_io_out = 8'h30;
      end
      S_READ: begin
        w_re_n      = (w_ph == 2'd2);
        w_out_valid = (w_ph == 2'd2);
      end
      S_HOLD: w_out_valid = 1'b1;
      S_DONE: begin
        w_ce_n = 1'b1;
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      S_ERR: begin
        w_ce_n = 1'b1;
        w_busy = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered pin and handshake outputs
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_ce_n      <= 1'b1;
      r_cle       <= 1'b0;
      r_ale       <= 1'b0;
      r_we_n      <= 1'b1;
      r_re_n      <= 1'b1;
      r_io_oe     <= 1'b0;
      r_io_out    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ce_n      <= w_ce_n;
      r_cle       <= w_cle;
      r_ale       <= w_ale;
      r_we_n      <= w_we_n;
      r_re_n      <= w_re_n;
      r_io_oe     <= w_io_oe;
      r_io_out    <= w_io_out;
      r_out_valid <= w_out_valid;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  // Address latch, read-byte capture at the end of R1, sticky timeout flag
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_data <= '0;
      r_terr <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_col  <= col_addr;
        r_row  <= row_addr;
        r_terr <= 1'b0;
      end
      if (w_state == S_ERR) r_terr <= 1'b1;
      if (r_state == S_READ && r_ph == 2'd1) r_data <= ndf_io_in;
    end
  end

`ifdef NDF_RDSUM_EN
  logic [7:0] r_sum;

  // Running XOR of accepted bytes, restarted by each accepted start
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_sum <= '0;
    end else if (w_start_acc) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum ^ r_data;
    end
  end

  assign rd_sum = r_sum;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_terr;
  assign ndf_ce_n    = r_ce_n;
  assign ndf_cle     = r_cle;
  assign ndf_ale     = r_ale;
  assign ndf_we_n    = r_we_n;
  assign ndf_re_n    = r_re_n;
  assign ndf_io_out  = r_io_out;
  assign ndf_io_oe   = r_io_oe;
  assign out_data    = r_data;
  assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_ndf_page_reader.sv
`timescale 1ns/1ps
// Directed bench for ndf_page_reader with a small NAND device model.
module tb_ndf_page_reader;
  localparam int unsigned PB  = 16;
  localparam int unsigned RBT = 50;
  localparam int unsigned TWB = 2;

  logic        clk10 = 1'b0;
  logic        rst, start, out_ready;
  logic [15:0] col_addr;
  logic [23:0] row_addr;
  logic        busy, done, timeout_err, ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n;
  logic        ndf_io_oe, out_valid;
  logic [7:0]  ndf_io_out, ndf_io_in, out_data;
  logic        ndf_r_b_n = 1'b1;
`ifdef NDF_RDSUM_EN
  logic [7:0]  rd_sum;
`endif

  always #50 clk10 = ~clk10;

  ndf_page_reader #(.PAGE_BYTES(PB), .RB_TIMEOUT(RBT), .TWB_CYCLES(TWB)) dut (
    .clk10(clk10), .rst(rst), .start(start), .col_addr(col_addr), .row_addr(row_addr),
    .busy(busy), .done(done), .timeout_err(timeout_err), .ndf_ce_n(ndf_ce_n),
    .ndf_cle(ndf_cle), .ndf_ale(ndf_ale), .ndf_we_n(ndf_we_n), .ndf_re_n(ndf_re_n),
    .ndf_io_out(ndf_io_out), .ndf_io_oe(ndf_io_oe), .ndf_io_in(ndf_io_in),
    .ndf_r_b_n(ndf_r_b_n), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef NDF_RDSUM_EN
    , .rd_sum(rd_sum)
`endif
  );

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int rb_lat = 40;
  bit rb_stuck = 1'b0;

  int cyc = 0, rd_idx = 0, rb_cnt = 0;
  logic [9:0] wr_q[$];
  int wr_last = 0;
  logic [7:0] acc_q[$];
  int acc_cyc_q[$];
  int done_n = 0, done_cyc = 0, vpulse = 0, terr_cyc = 0;
  int sp_viol = 0, we_viol = 0, wr_oe_viol = 0, oe_re_viol = 0, ce_viol = 0;
  int re_viol = 0, stab_viol = 0;
  logic prev_we = 1'b1, prev_re = 1'b1, prev_v = 1'b0, prev_r = 1'b0, prev_terr = 1'b0;
  logic [7:0] prev_d = '0;

  function automatic logic [7:0] nand_byte(input int m, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (m)
      1: case (i)
           0: return 8'hA5;
           1: return 8'h0F;
           2: return 8'hF0;
           3: return 8'h3C;
           default: return 8'h00;
         endcase
      2: return b ^ 8'h5A;
      default: return b;
    endcase
  endfunction

  assign ndf_io_in = nand_byte(mode, rd_idx);

  // NAND model plus bus/stream monitor, evaluated mid-cycle
  always @(negedge clk10) begin
    cyc <= cyc + 1;
    if (start && !busy && !rst) begin
      wr_q.delete();
      acc_q.delete();
      acc_cyc_q.delete();
      rd_idx <= 0;
      done_n <= 0;
      vpulse <= 0;
    end
    if (!ndf_we_n) begin
      if (wr_q.size() > 0 && cyc - wr_last != 2) sp_viol <= sp_viol + 1;
      wr_q.push_back({ndf_cle, ndf_ale, ndf_io_out});
      wr_last <= cyc;
      if (!ndf_io_oe) wr_oe_viol <= wr_oe_viol + 1;
      if (!prev_we) we_viol <= we_viol + 1;
    end
    if (!prev_we && ndf_we_n && ndf_cle && ndf_io_out == 8'h30) begin
      ndf_r_b_n <= 1'b0;
      rb_cnt <= rb_lat;
    end else if (rb_cnt > 0) begin
      rb_cnt <= rb_cnt - 1;
      if (rb_cnt == 1 && !rb_stuck) ndf_r_b_n <= 1'b1;
    end
    if (!prev_re && ndf_re_n) rd_idx <= rd_idx + 1;
    if (ndf_io_oe && !ndf_re_n) oe_re_viol <= oe_re_viol + 1;
    if (busy && ndf_ce_n) ce_viol <= ce_viol + 1;
    if (out_valid && !ndf_re_n) re_viol <= re_viol + 1;
    if (prev_v && !prev_r && out_valid && out_data !== prev_d) stab_viol <= stab_viol + 1;
    if (!prev_v && out_valid) vpulse <= vpulse + 1;
    if (out_valid && out_ready) begin
      acc_q.push_back(out_data);
      acc_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_n <= done_n + 1;
      done_cyc <= cyc;
    end
    if (timeout_err && !prev_terr) terr_cyc <= cyc;
    prev_we   <= ndf_we_n;
    prev_re   <= ndf_re_n;
    prev_v    <= out_valid;
    prev_r    <= out_ready;
    prev_d    <= out_data;
    prev_terr <= timeout_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk10);
      #1;
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ce_n"}, ndf_ce_n, 1);
    chk({p, "_cle"}, ndf_cle, 0);
    chk({p, "_ale"}, ndf_ale, 0);
    chk({p, "_we_n"}, ndf_we_n, 1);
    chk({p, "_re_n"}, ndf_re_n, 1);
    chk({p, "_io_oe"}, ndf_io_oe, 0);
    chk({p, "_io_out"}, ndf_io_out, 0);
    chk({p, "_out_valid"}, out_valid, 0);
    chk({p, "_out_data"}, out_data, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_terr"}, timeout_err, 0);
`ifdef NDF_RDSUM_EN
    chk({p, "_rd_sum"}, rd_sum, 0);
`endif
  endtask

  task automatic start_page(input logic [15:0] c, input logic [23:0] r);
    col_addr = c;
    row_addr = r;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Runs until done or timeout_err; also pulses start mid-run, which must be ignored
  task automatic wait_end(input bit toggle);
    logic [3:0] pat;
    bit ok;
    pat = 4'b1001;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      out_ready = toggle ? pat[k % 4] : 1'b1;
      start = (k == 60);
      tick(1);
      if (done || timeout_err) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("page_end_reached", ok, 1);
  endtask

  task automatic check_writes(input string p, input logic [15:0] c, input logic [23:0] r);
    logic [9:0] exp_wr[7];
    exp_wr[0] = {2'b10, 8'h00};
    exp_wr[1] = {2'b01, c[7:0]};
    exp_wr[2] = {2'b01, c[15:8]};
    exp_wr[3] = {2'b01, r[7:0]};
    exp_wr[4] = {2'b01, r[15:8]};
    exp_wr[5] = {2'b01, r[23:16]};
    exp_wr[6] = {2'b10, 8'h30};
    chk({p, "_wr_count"}, wr_q.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < wr_q.size()) chk($sformatf("%s_wr%0d", p, i), wr_q[i], exp_wr[i]);
  endtask

  task automatic check_bytes(input string p, input int m);
    chk({p, "_byte_count"}, acc_q.size(), PB);
    for (int i = 0; i < acc_q.size(); i++)
      chk($sformatf("%s_byte%0d", p, i), acc_q[i], nand_byte(m, i));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    col_addr = '0;
    row_addr = '0;
    tick(2);
    // start coincident with rst: rst wins
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk_reset("rst");
    rst = 1'b0;
    tick(2);

    // Page 1: full rate, col 0000h, row 012345h
    mode = 0;
    start_page(16'h0000, 24'h012345);
    chk("p1_busy_after_start", busy, 1);
    chk("p1_ce_n_after_start", ndf_ce_n, 0);
    wait_end(1'b0);
    chk("p1_done", done, 1);
    chk("p1_busy_at_done", busy, 0);
    chk("p1_ce_n_at_done", ndf_ce_n, 1);
    tick(2);
    chk("p1_done_cleared", done, 0);
    check_writes("p1", 16'h0000, 24'h012345);
    chk("p1_wr_spacing_viol", sp_viol, 0);
    chk("p1_we_low_viol", we_viol, 0);
    chk("p1_wr_oe_viol", wr_oe_viol, 0);
    check_bytes("p1", 0);
    for (int i = 1; i < acc_cyc_q.size(); i++)
      chk($sformatf("p1_rate%0d", i), acc_cyc_q[i] - acc_cyc_q[i-1], 3);
    if (acc_cyc_q.size() == PB) chk("p1_done_latency", done_cyc, acc_cyc_q[PB-1] + 1);
    chk("p1_done_pulses", done_n, 1);
    chk("p1_valid_pulses", vpulse, PB);

    // Page 2: back-pressure 1-0-0-1, different address and data pattern
    mode = 2;
    start_page(16'hBEEF, 24'hA1B2C3);
    wait_end(1'b1);
    chk("p2_done", done, 1);
    tick(2);
    check_writes("p2", 16'hBEEF, 24'hA1B2C3);
    check_bytes("p2", 2);
    chk("p2_stable_viol", stab_viol, 0);
    chk("p2_re_low_while_valid", re_viol, 0);
    chk("p2_done_pulses", done_n, 1);
    chk("p2_valid_pulses", vpulse, PB);

    // Page 3: R/B stuck low -> timeout after RB_TIMEOUT WAITRDY cycles
    mode = 0;
    rb_stuck = 1'b1;
    start_page(16'h0010, 24'h000020);
    wait_end(1'b0);
    chk("p3_terr", timeout_err, 1);
    chk("p3_no_done", done, 0);
    chk("p3_busy", busy, 0);
    chk("p3_ce_n", ndf_ce_n, 1);
    tick(2);
    // 30h W0 at wr_last, W1 +1, TWB 2 cycles, WAITRDY 50 cycles, ERR next
    chk("p3_terr_cycle", terr_cyc, wr_last + 2 + TWB + RBT);
    chk("p3_valid_pulses", vpulse, 0);
    chk("p3_bytes", acc_q.size(), 0);
    chk("p3_done_pulses", done_n, 0);
    tick(3);
    chk("p3_terr_sticky", timeout_err, 1);
    rb_stuck = 1'b0;
    start_page(16'h0010, 24'h000020);
    chk("p3_terr_cleared_by_start", timeout_err, 0);
    chk("p3_busy_restart", busy, 1);
    wait_end(1'b0);
    chk("p3b_done", done, 1);
    tick(2);
    check_bytes("p3b", 0);

    // Page 4: reset during the 7th read byte
    mode = 0;
    start_page(16'h0002, 24'h000003);
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        tick(1);
        if (acc_q.size() == 6 && !ndf_re_n) begin
          hit = 1'b1;
          break;
        end
      end
      chk("p4_reached_byte7", hit, 1);
    end
    rst = 1'b1;
    tick(1);
    chk_reset("midrst");
    rst = 1'b0;
    tick(4);
    chk("p4_no_done", done_n, 0);
    chk("p4_no_partial_byte", acc_q.size(), 6);
    chk("p4_valid_pulses", vpulse, 6);
    chk("p4_idle_busy", busy, 0);
    start_page(16'h0002, 24'h000003);
    wait_end(1'b0);
    chk("p4b_done", done, 1);
    tick(2);
    check_writes("p4b", 16'h0002, 24'h000003);
    check_bytes("p4b", 0);
    chk("p4b_done_pulses", done_n, 1);

`ifdef NDF_RDSUM_EN
    // Page 5: A5h, 0Fh, F0h, 3Ch then zeros -> XOR 66h
    mode = 1;
    start_page(16'h0000, 24'h000001);
    wait_end(1'b0);
    chk("p5_done", done, 1);
    chk("p5_rd_sum_at_done", rd_sum, 8'h66);
    tick(3);
    chk("p5_rd_sum_stable", rd_sum, 8'h66);
    check_bytes("p5", 1);
`endif

    chk("all_ce_viol", ce_viol, 0);
    chk("all_oe_while_re_low", oe_re_viol, 0);
    chk("all_re_low_while_valid", re_viol, 0);
    chk("all_stable_viol", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
